// File: rtl/leaf_frame_acc_pkg.sv
// Shared types and width helpers for the leaf frame accumulator.
package leaf_frame_acc_pkg;

  // Accumulator control states
  typedef enum logic {
    ACCUM = 1'b0,
    STALL = 1'b1
  } state_e;

  // Sum width large enough that frame_len beats of all-ones never wrap
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned frame_len);
    return data_w + $clog2(frame_len);
  endfunction

  // Count width able to represent 0..frame_len
  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/leaf_result_reg.sv
// One-deep valid/ready holding register for completed frame results.
module leaf_result_reg
  import leaf_frame_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ACC_W-1:0] load_sum,
  input  logic [CNT_W-1:0] load_count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);

  logic             valid_q, valid_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Load wins over consume so back-to-back results keep valid high
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    count_d = count_q;
    if (load) begin
      valid_d = 1'b1;
      sum_d   = load_sum;
      count_d = load_count;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Result register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_count = count_q;

endmodule

// File: rtl/leaf_frame_accumulator.sv
// Leaf frame accumulator: sums frames of up to FRAME_LEN beats and emits
// {sum, count} per frame through a one-deep output register.
// Optional build macro LEAF_FRAME_ACC_STATS_EN adds a frames_done counter port.
module leaf_frame_accumulator
  import leaf_frame_acc_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ACC_W     = acc_width(DATA_W, FRAME_LEN),
  parameter int unsigned CNT_W     = cnt_width(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
`ifdef LEAF_FRAME_ACC_STATS_EN
  ,
  output logic [15:0]       frames_done
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             in_hs;
  logic             frame_end;
  logic             out_free;
  logic [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_next;
  logic             load;
  logic [ACC_W-1:0] load_sum;
  logic [CNT_W-1:0] load_count;

  // Ready is a function of state only; forced low while reset is asserted
  assign in_ready  = (state_q == ACCUM) && !rst;
  assign in_hs     = in_valid && in_ready;
  assign frame_end = in_last || (beat_cnt_q == LAST_IDX);
  assign out_free  = !out_valid || out_ready;
  assign sum_next  = acc_q + ACC_W'(in_data);
  assign cnt_next  = beat_cnt_q + CNT_W'(1);

  // Next-state, accumulate and result-load decisions
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    load       = 1'b0;
    load_sum   = '0;
    load_count = '0;
    case (state_q)
      ACCUM: begin
        if (in_hs) begin
          if (frame_end && out_free) begin
            load       = 1'b1;
            load_sum   = sum_next;
            load_count = cnt_next;
            acc_d      = '0;
            beat_cnt_d = '0;
          end else begin
            // Completed frame parks here when the output register is busy
            acc_d      = sum_next;
            beat_cnt_d = cnt_next;
            if (frame_end) begin
              state_d = STALL;
            end
          end
        end
      end
      STALL: begin
        if (out_ready) begin
          load       = 1'b1;
          load_sum   = acc_q;
          load_count = beat_cnt_q;
          acc_d      = '0;
          beat_cnt_d = '0;
          state_d    = ACCUM;
        end
      end
    endcase
  end

  // State and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  leaf_result_reg #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_result_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_sum   (load_sum),
    .load_count (load_count),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_sum    (out_sum),
    .out_count  (out_count)
  );

`ifdef LEAF_FRAME_ACC_STATS_EN
  logic [15:0] frames_done_q, frames_done_d;

  // Count consumed results, wrapping naturally at 16 bits
  always_comb begin
    frames_done_d = frames_done_q;
    if (out_valid && out_ready) begin
      frames_done_d = frames_done_q + 16'(1);
    end
  end

  // Consumed-result counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_done_q <= '0;
    end else begin
      frames_done_q <= frames_done_d;
    end
  end

  assign frames_done = frames_done_q;
`endif

endmodule

// File: tb/tb_leaf_frame_accumulator.sv
// Self-checking bench for leaf_frame_accumulator (DATA_W=8, FRAME_LEN=16).
module tb_leaf_frame_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic [4:0]  out_count;
`ifdef LEAF_FRAME_ACC_STATS_EN
  logic [15:0] frames_done;
  int          exp_done;
`endif

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [15:0][7:0] data;
    int               n;
    bit               use_last;
    int               exp_sum;
    int               exp_cnt;
  } vec_t;

  vec_t vecs[7];

  leaf_frame_accumulator #(
    .DATA_W    (8),
    .FRAME_LEN (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
`ifdef LEAF_FRAME_ACC_STATS_EN
    ,
    .frames_done (frames_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Presents one beat; returns #1 after the accepting edge
  task automatic drive_beat(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int s, input int c);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".sum"},   32'(out_sum),   32'(s));
    check({tag, ".count"}, 32'(out_count), 32'(c));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
`ifdef LEAF_FRAME_ACC_STATS_EN
    exp_done = 0;
`endif

    // Vector table: hand-computed sums and counts
    for (int k = 0; k < 7; k++) begin
      vecs[k].data = '0;
    end
    for (int b = 0; b < 16; b++) vecs[0].data[b] = 8'h01;
    vecs[0].n = 16; vecs[0].use_last = 1'b0; vecs[0].exp_sum = 16;   vecs[0].exp_cnt = 16;
    for (int b = 0; b < 16; b++) vecs[1].data[b] = 8'hFF;
    vecs[1].n = 16; vecs[1].use_last = 1'b0; vecs[1].exp_sum = 4080; vecs[1].exp_cnt = 16;
    vecs[2].data[0] = 8'd3; vecs[2].data[1] = 8'd5;
    vecs[2].n = 2;  vecs[2].use_last = 1'b1; vecs[2].exp_sum = 8;    vecs[2].exp_cnt = 2;
    vecs[3].data[0] = 8'd7;
    vecs[3].n = 1;  vecs[3].use_last = 1'b1; vecs[3].exp_sum = 7;    vecs[3].exp_cnt = 1;
    for (int b = 0; b < 16; b++) vecs[4].data[b] = 8'(b);
    vecs[4].n = 16; vecs[4].use_last = 1'b0; vecs[4].exp_sum = 120;  vecs[4].exp_cnt = 16;
    for (int b = 0; b < 16; b++) vecs[5].data[b] = 8'd2;
    vecs[5].n = 16; vecs[5].use_last = 1'b1; vecs[5].exp_sum = 32;   vecs[5].exp_cnt = 16;
    vecs[6].data[0] = 8'hFF; vecs[6].data[1] = 8'h80; vecs[6].data[2] = 8'h01; vecs[6].data[3] = 8'h10;
    vecs[6].n = 4;  vecs[6].use_last = 1'b1; vecs[6].exp_sum = 400;  vecs[6].exp_cnt = 4;

    // Reset state
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_sum",   32'(out_sum),   32'd0);
    check("rst.out_count", 32'(out_count), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    step();

    // Table-driven frames with the consumer always ready
    for (int k = 0; k < 7; k++) begin
      for (int b = 0; b < vecs[k].n; b++) begin
        check($sformatf("vec%0d.in_ready%0d", k, b), 32'(in_ready), 32'd1);
        drive_beat(vecs[k].data[b], vecs[k].use_last && (b == vecs[k].n - 1));
      end
      check_result($sformatf("vec%0d", k), vecs[k].exp_sum, vecs[k].exp_cnt);
      step();
      check($sformatf("vec%0d.valid_drop", k), 32'(out_valid), 32'd0);
`ifdef LEAF_FRAME_ACC_STATS_EN
      exp_done++;
`endif
    end
`ifdef LEAF_FRAME_ACC_STATS_EN
    check("stats.after_table", 32'(frames_done), 32'(exp_done));
`endif

    // Back-to-back one-beat frames: valid stays high across the swap
    drive_beat(8'd4, 1'b1);
    check_result("b2b.first", 4, 1);
    drive_beat(8'd6, 1'b1);
    check_result("b2b.second", 6, 1);
    step();
    check("b2b.valid_drop", 32'(out_valid), 32'd0);
`ifdef LEAF_FRAME_ACC_STATS_EN
    exp_done += 2;
`endif

    // Stall: frame A held, frame B parked, input blocked
    out_ready = 1'b0;
    for (int b = 0; b < 16; b++) drive_beat(8'd1, 1'b0);
    check_result("stall.A", 16, 16);
    for (int b = 0; b < 16; b++) begin
      check($sformatf("stall.B.in_ready%0d", b), 32'(in_ready), 32'd1);
      drive_beat(8'd2, 1'b0);
    end
    check("stall.in_ready", 32'(in_ready), 32'd0);
    check_result("stall.A_held", 16, 16);
    in_valid = 1'b1;
    in_data  = 8'h50;
    step();
    step();
    check("stall.in_ready_hold", 32'(in_ready), 32'd0);
    check_result("stall.A_held2", 16, 16);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_result("stall.B", 32, 16);
    check("stall.release_in_ready", 32'(in_ready), 32'd1);
    step();
    check("stall.B_drop", 32'(out_valid), 32'd0);
    drive_beat(8'd9, 1'b1);
    check_result("stall.after", 9, 1);
    step();
`ifdef LEAF_FRAME_ACC_STATS_EN
    exp_done += 3;
    check("stats.after_stall", 32'(frames_done), 32'(exp_done));
`endif

    // Mid-frame reset with a pending result discards both
    out_ready = 1'b0;
    for (int b = 0; b < 16; b++) drive_beat(8'd1, 1'b0);
    check_result("rst2.pending", 16, 16);
    for (int b = 0; b < 7; b++) drive_beat(8'd1, 1'b0);
    rst = 1'b1;
    step();
    check("rst2.out_valid", 32'(out_valid), 32'd0);
    check("rst2.out_sum",   32'(out_sum),   32'd0);
    check("rst2.out_count", 32'(out_count), 32'd0);
    check("rst2.in_ready",  32'(in_ready),  32'd0);
`ifdef LEAF_FRAME_ACC_STATS_EN
    exp_done = 0;
    check("stats.reset", 32'(frames_done), 32'd0);
`endif
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    for (int b = 0; b < 16; b++) drive_beat(8'd1, 1'b0);
    check_result("rst2.fresh", 16, 16);
    step();
    check("rst2.valid_drop", 32'(out_valid), 32'd0);
`ifdef LEAF_FRAME_ACC_STATS_EN
    exp_done++;
    check("stats.final", 32'(frames_done), 32'(exp_done));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/leaf_frame_accumulator.md
Name: leaf_frame_accumulator

Overview:
Sequential leaf stage instantiated beneath each generated hierarchy node.
- Consumes a valid/ready data stream and sums each frame of up to FRAME_LEN beats.
- Emits one result per frame: the sum and the beat count, on a valid/ready output port.
- Uses a one-deep output register, so the next frame can be accumulated while the previous result waits for the consumer.

Parameters:
DATA_W, 8, input beat width (unsigned)
FRAME_LEN, 16, maximum beats per frame; must be at least 2
ACC_W, DATA_W+$clog2(FRAME_LEN), accumulator and result width
CNT_W, $clog2(FRAME_LEN+1), beat-count width

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  DATA_W  beat payload, unsigned
in_last  in  1  early end-of-frame marker, qualified by in_valid
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_sum  out  ACC_W  frame sum
out_count  out  CNT_W  beats in frame, 1..FRAME_LEN

Behaviour:
Reset (rst=1 at posedge):
- out_valid=0, out_sum=0, out_count=0, in_ready=0 during reset cycle.
- acc=0, beat_cnt=0, state=ACCUM.
- Mid-frame reset discards the partial frame and any pending result.

States: ACCUM, STALL.

ACCUM:
- in_ready=1.
- On handshake: acc+=in_data (zero-extended); beat_cnt+=1.
- Frame ends when in_last=1 or beat_cnt==FRAME_LEN-1 at the handshake.

Frame end:
- If the output register is free (out_valid==0, or out_ready==1 this cycle): next cycle out_sum = acc+in_data, out_count = beat_cnt+1, out_valid=1; acc and beat_cnt clear; stay in ACCUM.
- Otherwise: hold the completed sum in acc and the count in beat_cnt; go to STALL.

STALL:
- in_ready=0.
- On out_ready: transfer acc/beat_cnt to the output register (out_valid stays 1); clear acc and beat_cnt; return to ACCUM.
- Latency: result is visible one cycle after the frame-end handshake or after the stall release.

Output hold:
- out_sum and out_count stay stable while out_valid && !out_ready.
- out_valid drops the cycle after consumption unless a new result loads in the same cycle (back-to-back results allowed).

Boundary cases:
- A one-beat frame (in_last on the first beat) gives out_count=1.
- in_last on beat FRAME_LEN is redundant, no error.
- No wrap-around: ACC_W holds FRAME_LEN*max(in_data).
- in_ready depends combinationally only on state, never on out_ready.

Optional Feature:
Macro: LEAF_FRAME_ACC_STATS_EN
- Defined: adds output port frames_done [15:0], a count of results consumed. Reset 0; increments on each out_valid&&out_ready; wraps 0xFFFF→0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
Package leaf_frame_acc_pkg:
- state enum (ACCUM, STALL)
- function computing ACC_W/CNT_W from DATA_W and FRAME_LEN

Sub-module leaf_result_reg: the one-deep valid/ready output holding register (load, hold, consume).

Test Plan:
1. Reset then 16 beats of 0x01 with out_ready=1 → out_sum=16, out_count=16, one cycle after the last beat; out_valid high exactly 1 cycle.
2. 16 beats of 0xFF → out_sum=0xFF0 (4080), no overflow with ACC_W=12.
3. Beats 3,5 with in_last on 5 → out_sum=8, out_count=2; next frame starts from 0.
4. out_ready=0; frame A (16×1) completes, then frame B (16×2) completes → A held stable, in_ready=0 in STALL. Raise out_ready → A consumed, B appears next cycle (sum=32), in_ready=1.
5. Reset asserted after 7 beats → outputs 0; the next 16 beats of 1 give sum=16, not 23.
6. With LEAF_FRAME_ACC_STATS_EN defined: consume 3 results → frames_done=3. With it undefined, the build has no frames_done port.
